// File: rtl/m_store_pack.sv
// Store packer: lane-replicates store data, builds byte enables and queues
// packed writes in a 2-entry in-order FIFO toward memory.
module m_store_pack #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] tail_addr;
    logic [31:0]       tail_wdata;
    logic [3:0]        tail_be;

    logic              legal;
    logic [3:0]        pk_be;
    logic [31:0]       pk_wdata;
    logic [ADDR_W-1:0] pk_addr;
    logic              accept;
    logic              push;
    logic              pop;

    always_comb begin
        legal    = 1'b0;
        pk_be    = '0;
        pk_wdata = '0;
        case (req_type)
            2'b00: begin
                legal    = (req_addr[1:0] == 2'b00);
                pk_be    = 4'b1111;
                pk_wdata = req_data;
            end
            2'b01: begin
                legal    = !req_addr[0];
                pk_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                pk_wdata = {2{req_data[15:0]}};
            end
            2'b10: begin
                legal    = 1'b1;
                pk_be    = 4'b0001 << req_addr[1:0];
                pk_wdata = {4{req_data[7:0]}};
            end
            default: ;
        endcase
        pk_addr = {req_addr[ADDR_W-1:2], 2'b00};
    end

    // Handshakes depend only on registered state, so mem_ready never reaches req_ready.
    assign req_ready = (state != FULL);
    assign mem_valid = (state != EMPTY);
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;
    assign pop       = mem_valid && mem_ready;

    // The head entry lives directly in the mem_* output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            tail_addr  <= '0;
            tail_wdata <= '0;
            tail_be    <= '0;
            err_valid  <= 1'b0;
            err_addr   <= '0;
        end else begin
            err_valid <= accept && !legal;
            if (accept && !legal) begin
                err_addr <= req_addr;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        mem_addr  <= pk_addr;
                        mem_wdata <= pk_wdata;
                        mem_be    <= pk_be;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        mem_addr  <= pk_addr;
                        mem_wdata <= pk_wdata;
                        mem_be    <= pk_be;
                    end else if (push) begin
                        tail_addr  <= pk_addr;
                        tail_wdata <= pk_wdata;
                        tail_be    <= pk_be;
                        state      <= FULL;
                    end else if (pop) begin
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        mem_addr   <= tail_addr;
                        mem_wdata  <= tail_wdata;
                        mem_be     <= tail_be;
                        tail_addr  <= '0;
                        tail_wdata <= '0;
                        tail_be    <= '0;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_m_store_pack.sv
// Scoreboard bench for m_store_pack: directed scenarios plus randomized
// traffic checked against an arithmetic packing model.
module tb_m_store_pack;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_type = '0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          err_valid;
    logic [AW-1:0] err_addr;

    int total = 0;
    int bad = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t         q[$];
    wr_t         w_new;
    bit          err_pend = 1'b0;
    logic [31:0] err_exp = '0;

    m_store_pack #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a store of N bytes is legal when addr is a multiple of N;
    // data replicates across the word and enables cover N bytes at addr%4.
    function automatic bit model(input logic [1:0] t, input logic [31:0] a,
                                 input logic [31:0] d, output wr_t w);
        int unsigned size;
        w.addr  = a - (a % 32'd4);
        w.wdata = '0;
        w.be    = '0;
        case (t)
            2'd0: size = 4;
            2'd1: size = 2;
            2'd2: size = 1;
            default: return 1'b0;
        endcase
        if ((a % size) != 0) return 1'b0;
        if (size == 4) begin
            w.be    = 4'hF;
            w.wdata = d;
        end else if (size == 2) begin
            w.be    = 4'(32'd3 << (a % 32'd4));
            w.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            w.be    = 4'(32'd1 << (a % 32'd4));
            w.wdata = (d & 32'hFF) * 32'h0101_0101;
        end
        return 1'b1;
    endfunction

    // Monitor: checks bus against the model queue each cycle, then records
    // the request that will be taken on the coming rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            err_pend = 1'b0;
        end else begin
            chk("req_ready", 64'(req_ready), 64'(q.size() < 2));
            chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
                chk("mem_be", 64'(mem_be), 64'(q[0].be));
                if (mem_ready) void'(q.pop_front());
            end else begin
                chk("idle_bus", 64'(mem_addr | mem_wdata | {28'd0, mem_be}), 64'd0);
            end
            chk("err_valid", 64'(err_valid), 64'(err_pend));
            if (err_pend) chk("err_addr", 64'(err_addr), 64'(err_exp));
            err_pend = 1'b0;
            if (req_valid && req_ready) begin
                if (model(req_type, req_addr, req_data, w_new)) q.push_back(w_new);
                else begin
                    err_pend = 1'b1;
                    err_exp  = req_addr;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 mem_ready = 1'($urandom % 2);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
    task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no req_ready expected accept of %0h", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1;
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_bus", 64'(mem_addr | mem_wdata | {28'd0, mem_be}), 64'd0);
        chk("rst_err", 64'(err_addr | {31'd0, err_valid}), 64'd0);
        #16 reset_n = 1'b1;

        // Byte store at 0x1003, popped the cycle it appears
        mem_ready = 1'b1;
        send(2'b10, 32'h1003, 32'h0000_00AB);
        chk("byte_valid", 64'(mem_valid), 64'd1);
        chk("byte_addr", 64'(mem_addr), 64'h1000);
        chk("byte_be", 64'(mem_be), 64'b1000);
        chk("byte_wdata", 64'(mem_wdata), 64'hABAB_ABAB);
        idle(1);
        chk("byte_popped", 64'(mem_valid), 64'd0);

        send(2'b01, 32'h2002, 32'h1234_CDEF);
        chk("half_be", 64'(mem_be), 64'b1100);
        chk("half_wdata", 64'(mem_wdata), 64'hCDEF_CDEF);
        chk("half_addr", 64'(mem_addr), 64'h2000);
        idle(2);

        // Misaligned word and reserved type
        send(2'b00, 32'h3001, 32'h5555_5555);
        req_valid = 1'b0;
        chk("mis_err", 64'(err_valid), 64'd1);
        chk("mis_err_addr", 64'(err_addr), 64'h3001);
        chk("mis_no_write", 64'(mem_valid), 64'd0);
        idle(1);
        chk("mis_err_once", 64'(err_valid), 64'd0);
        send(2'b11, 32'h3000, 32'h1);
        req_valid = 1'b0;
        chk("rsv_err", 64'(err_valid), 64'd1);
        chk("rsv_err_addr", 64'(err_addr), 64'h3000);
        idle(1);
        chk("rsv_err_once", 64'(err_valid), 64'd0);

        // Backpressure: two fill the FIFO, third waits until drain
        mem_ready = 1'b0;
        send(2'b00, 32'h100, 32'hA0A0_0001);
        send(2'b00, 32'h104, 32'hB0B0_0002);
        chk("bp_full", 64'(req_ready), 64'd0);
        fork
            send(2'b00, 32'h108, 32'hC0C0_0003);
            begin
                repeat (4) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        idle(4);

        // Push and pop together while holding one entry
        send(2'b00, 32'h200, 32'h1111_1111);
        send(2'b10, 32'h205, 32'h0000_0022);
        chk("pp_valid", 64'(mem_valid), 64'd1);
        chk("pp_head", 64'(mem_addr), 64'h204);
        chk("pp_ready", 64'(req_ready), 64'd1);
        idle(3);

        // Reset while FULL and stalled
        mem_ready = 1'b0;
        send(2'b00, 32'h300, 32'hDEAD_0001);
        send(2'b00, 32'h304, 32'hDEAD_0002);
        idle(2);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_bus", 64'(mem_addr | mem_wdata | {28'd0, mem_be}), 64'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        idle(5);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 4 == 0) idle(1);
            else send(2'($urandom_range(0, 3)), $urandom & 32'h0000_FFFF, $urandom);
        end
        idle(1);
        rand_ready = 1'b0;
        @(posedge clk);
        #2 mem_ready = 1'b1;
        idle(10);
        chk("drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_store_pack.md
M_STORE_PACK -- requirements
Module: m_store_pack

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of the request and memory address buses.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  store request present.
REQ-005 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port req_type  input  2  store width: 00 word, 01 half, 10 byte, 11 reserved.
REQ-007 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-008 SHALL have port req_data  input  32  store data, right-justified.
REQ-009 SHALL have port mem_valid  output  1  memory write present.
REQ-010 SHALL have port mem_ready  input  1  memory accepts the write.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word-aligned address, with bits [1:0] always 00.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-013 SHALL have port mem_be  output  4  byte enables, where bit i enables bits [8i+7:8i].
REQ-014 SHALL have port err_valid  output  1  one-cycle misalignment/illegal-type pulse.
REQ-015 SHALL have port err_addr  output  ADDR_W  address of the rejected request.

Function
REQ-016 SHALL hold a 2-entry in-order FIFO of packed writes; its occupancy states are EMPTY (0), ONE (1) and FULL (2).
REQ-017 SHALL drive req_ready = (state != FULL) from registered state only, with no combinational path from mem_ready.
REQ-018 SHALL accept a request on a rising clk edge where req_valid && req_ready.
REQ-019 SHALL pack an accepted word request as: be=1111, wdata=req_data; legal only when addr[1:0]=00.
REQ-020 SHALL pack an accepted half request as: be=0011 if addr[1]=0, else 1100; wdata={2{req_data[15:0]}}; legal only when addr[0]=0.
REQ-021 SHALL pack an accepted byte request as: be=0001<<addr[1:0]; wdata={4{req_data[7:0]}}; always legal.
REQ-022 SHALL set the stored mem_addr to {req_addr[ADDR_W-1:2],2'b00}.
REQ-023 SHALL not enqueue an accepted illegal request (misaligned, or type 11); it SHALL set err_valid=1 and err_addr=req_addr on the following cycle, for one cycle only.
REQ-024 SHALL drive mem_valid = (state != EMPTY) and present the head entry on mem_addr/mem_wdata/mem_be.
REQ-025 SHALL pop the head on a clk edge where mem_valid && mem_ready.
REQ-026 SHALL hold mem_addr/mem_wdata/mem_be stable while mem_valid=1 and mem_ready=0.
REQ-027 SHALL take these state transitions: push only -> +1; pop only -> -1; push+pop in ONE -> stay ONE with the new entry at head next cycle; push+pop in EMPTY is impossible; push in FULL is impossible.
REQ-028 SHALL treat a simultaneous illegal accept and pop as a pop only (occupancy -1) plus the err pulse.
REQ-029 SHALL give a one-cycle accept-to-mem_valid latency from EMPTY, and SHALL NOT bypass the FIFO.
REQ-030 SHALL drive mem_addr/mem_wdata/mem_be to 0 when EMPTY.

Reset
REQ-031 SHALL, on reset_n=0 (at any time, including mid-transfer), immediately set state=EMPTY, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, err_valid=0, err_addr=0 and req_ready=1, and SHALL discard any queued entries.
REQ-032 SHALL accept its first request on the first rising clk edge after reset_n deasserts.

Verification
REQ-033 Byte store: type=10, addr=0x1003, data=0x000000AB, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB; popped on that edge.
REQ-034 Half store: type=01, addr=0x2002, data=0x1234CDEF -> mem_be=1100, mem_wdata=0xCDEFCDEF, mem_addr=0x2000.
REQ-035 Backpressure: mem_ready=0, three word stores issued back-to-back -> first two accepted, req_ready=0 on the third; mem_ready=1 -> writes drain in order, then the third is accepted.
REQ-036 Misaligned: word at 0x3001 -> no mem_valid, err_valid=1 for exactly one cycle, err_addr=0x3001; type=11 at 0x3000 -> same behaviour with err_addr=0x3000.
REQ-037 Push+pop in ONE: head=A, mem_ready=1, new request B accepted on the same edge -> next cycle state ONE, head=B, mem_valid stays 1.
REQ-038 Reset mid-operation: FULL with mem_ready=0, then pull reset_n low -> outputs are 0 and req_ready=1 without waiting for a clk edge; no stale write appears after reset is released.
